// File: rtl/mips_pkg.sv
// Shared EX-stage encodings: ALU op codes, mult/div FSM states and mult/div op select.
package mips_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_MFHI = 4'd12,
        OP_MFLO = 4'd13,
        OP_MULT = 4'd14,
        OP_DIV  = 4'd15
    } aluop_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } md_op_e;

    function automatic logic is_md_op(input aluop_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative signed MULT/DIV with HI/LO: one bit per cycle, WIDTH busy cycles per operation.
// The divider datapath exists only when EXECUTE_DIV_EN is defined.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CW = $clog2(WIDTH);

    md_state_e          r_state, w_state_next;
    logic [CW-1:0]      r_cnt;
    md_op_e             r_op;
    logic [WIDTH:0]     r_upper;
    logic [WIDTH-1:0]   r_lower, r_opnd, r_hi, r_lo;
    logic               r_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_addend;
    logic [WIDTH:0]     w_sum, w_upper_next;
    logic [WIDTH-1:0]   w_lower_next, w_hi_fin, w_lo_fin;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_last;
`ifdef EXECUTE_DIV_EN
    logic               r_neg_rem, r_dz;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
`endif

    assign busy   = (r_state == MD_BUSY);
    assign w_last = (r_cnt == '0);
    assign hi     = r_hi;
    assign lo     = r_lo;

    assign w_mag_a = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + 1'b1) : b;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            MD_IDLE: if (start)  w_state_next = MD_BUSY;
            MD_BUSY: if (w_last) w_state_next = MD_IDLE;
            default:             w_state_next = MD_IDLE;
        endcase
    end

    // r_lower holds multiplier / dividend magnitude, shifted out (mult) or in (div) one bit per cycle
    always_comb begin
        w_upper_next = r_upper;
        w_lower_next = r_lower;
        w_addend     = r_lower[0] ? r_opnd : '0;
        w_sum        = r_upper + {1'b0, w_addend};
        if (r_op == MD_MULT) begin
            {w_upper_next, w_lower_next} = {1'b0, w_sum, r_lower[WIDTH-1:1]};
        end
`ifdef EXECUTE_DIV_EN
        w_shift = {r_upper[WIDTH-1:0], r_lower[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_opnd});
        if (r_op == MD_DIV) begin
            w_upper_next = w_ge ? (w_shift - {1'b0, r_opnd}) : w_shift;
            w_lower_next = {r_lower[WIDTH-2:0], w_ge};
        end
`endif
    end

    always_comb begin
        w_prod = {w_upper_next[WIDTH-1:0], w_lower_next};
        if (r_neg) w_prod = ~w_prod + 1'b1;
        w_hi_fin = w_prod[2*WIDTH-1:WIDTH];
        w_lo_fin = w_prod[WIDTH-1:0];
`ifdef EXECUTE_DIV_EN
        if (r_op == MD_DIV) begin
            if (r_dz) begin
                w_hi_fin = r_dividend;
                w_lo_fin = '1;
            end else begin
                w_lo_fin = r_neg ? (~w_lower_next + 1'b1) : w_lower_next;
                w_hi_fin = r_neg_rem ? (~w_upper_next[WIDTH-1:0] + 1'b1) : w_upper_next[WIDTH-1:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= MD_IDLE;
            r_cnt      <= '0;
            r_op       <= MD_MULT;
            r_upper    <= '0;
            r_lower    <= '0;
            r_opnd     <= '0;
            r_neg      <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
`ifdef EXECUTE_DIV_EN
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_dividend <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            if ((r_state == MD_IDLE) && start) begin
                r_cnt   <= CW'(WIDTH - 1);
                r_op    <= op;
                r_upper <= '0;
                r_lower <= w_mag_a;
                r_opnd  <= w_mag_b;
                r_neg   <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef EXECUTE_DIV_EN
                r_neg_rem  <= a[WIDTH-1];
                r_dz       <= (b == '0);
                r_dividend <= a;
`endif
            end else if (busy) begin
                r_cnt   <= r_cnt - 1'b1;
                r_upper <= w_upper_next;
                r_lower <= w_lower_next;
                if (w_last) begin
                    r_hi <= w_hi_fin;
                    r_lo <= w_lo_fin;
                end
            end
        end
    end

endmodule

// File: rtl/execute.sv
// EX stage: operand select, ALU, EX/MEM register and the HI/LO mult/div unit.
// Define EXECUTE_DIV_EN to build DIV; otherwise op 15 retires as a NOP.
module execute
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       wbi,
    input  logic             mi,
    input  logic [3:0]       aluop,
    input  logic             alusrc,
    input  logic             regdst,
    input  logic [WIDTH-1:0] rsdata,
    input  logic [WIDTH-1:0] rtdata,
    input  logic [WIDTH-1:0] imm,
    input  logic [4:0]       shamt,
    input  logic [4:0]       rt,
    input  logic [4:0]       rd,
    output logic [1:0]       wbo,
    output logic             mo,
    output logic [WIDTH-1:0] dataout,
    output logic [WIDTH-1:0] aluresult,
    output logic [4:0]       regaddrout,
    output logic             stall
);
    aluop_e           w_op;
    md_op_e           w_md_op;
    logic [WIDTH-1:0] w_b, w_alu, w_hi, w_lo;
    logic             w_busy, w_stall, w_md_slot, w_md_issue, w_start;
    logic [1:0]       r_wbo;
    logic             r_mo;
    logic [WIDTH-1:0] r_dataout, r_aluresult;
    logic [4:0]       r_regaddr;

    assign w_op      = aluop_e'(aluop);
    assign w_b       = alusrc ? imm : rtdata;
    assign w_md_slot = is_md_op(w_op);
`ifdef EXECUTE_DIV_EN
    assign w_md_issue = w_md_slot;
`else
    assign w_md_issue = (w_op == OP_MULT);
`endif
    assign w_stall = w_busy && (w_md_issue || (w_op == OP_MFHI) || (w_op == OP_MFLO));
    assign w_start = w_md_issue && !w_busy;
    assign w_md_op = (w_op == OP_DIV) ? MD_DIV : MD_MULT;
    assign stall   = w_stall;

    muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .rst_n (reset),
        .start (w_start),
        .op    (w_md_op),
        .a     (rsdata),
        .b     (w_b),
        .busy  (w_busy),
        .hi    (w_hi),
        .lo    (w_lo)
    );

    // Shifts and LUI act on operand B, matching MIPS rt-based shift encoding
    always_comb begin
        w_alu = '0;
        unique case (w_op)
            OP_ADD:  w_alu = rsdata + w_b;
            OP_SUB:  w_alu = rsdata - w_b;
            OP_AND:  w_alu = rsdata & w_b;
            OP_OR:   w_alu = rsdata | w_b;
            OP_XOR:  w_alu = rsdata ^ w_b;
            OP_NOR:  w_alu = ~(rsdata | w_b);
            OP_SLT:  w_alu[0] = ($signed(rsdata) < $signed(w_b));
            OP_SLTU: w_alu[0] = (rsdata < w_b);
            OP_SLL:  w_alu = w_b << shamt;
            OP_SRL:  w_alu = w_b >> shamt;
            OP_SRA:  w_alu = $signed(w_b) >>> shamt;
            OP_LUI:  w_alu = w_b << 16;
            OP_MFHI: w_alu = w_hi;
            OP_MFLO: w_alu = w_lo;
            default: w_alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wbo       <= '0;
            r_mo        <= 1'b0;
            r_dataout   <= '0;
            r_aluresult <= '0;
            r_regaddr   <= '0;
        end else if (w_stall) begin
            r_wbo       <= '0;
            r_mo        <= 1'b0;
            r_dataout   <= '0;
            r_aluresult <= '0;
            r_regaddr   <= '0;
        end else begin
            r_wbo       <= w_md_slot ? 2'b00 : wbi;
            r_mo        <= w_md_slot ? 1'b0 : mi;
            r_dataout   <= rtdata;
            r_aluresult <= w_alu;
            r_regaddr   <= regdst ? rd : rt;
        end
    end

    assign wbo        = r_wbo;
    assign mo         = r_mo;
    assign dataout    = r_dataout;
    assign aluresult  = r_aluresult;
    assign regaddrout = r_regaddr;

endmodule
